// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan decoder.
//   SEG_*      : active-low segment patterns, bit0=a .. bit6=g
//   BCD_BLANK  : nibble reported for a dark digit
//   BCD_ERR    : nibble reported for an unrecognised pattern
//   state_e    : frame assembly state
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_ERR   = 4'hE;

  typedef enum logic {
    COLLECT,
    FULL
  } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to BCD decoder; exact inverse of the display encoder.
//   seg    in  7  active-low segment lines
//   nibble out 4  BCD digit, BCD_BLANK or BCD_ERR
//   blank  out 1  pattern was all segments off
//   error  out 1  pattern is not a legal digit or blank
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       error
);

  always_comb begin
    nibble = BCD_ERR;
    blank  = 1'b0;
    error  = 1'b0;
    case (seg)
      SEG_0:     nibble = 4'd0;
      SEG_1:     nibble = 4'd1;
      SEG_2:     nibble = 4'd2;
      SEG_3:     nibble = 4'd3;
      SEG_4:     nibble = 4'd4;
      SEG_5:     nibble = 4'd5;
      SEG_6:     nibble = 4'd6;
      SEG_7:     nibble = 4'd7;
      SEG_8:     nibble = 4'd8;
      SEG_9:     nibble = 4'd9;
      SEG_BLANK: begin
        nibble = BCD_BLANK;
        blank  = 1'b1;
      end
      default:   error = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Multiplexed 7-segment bus monitor: waits for each digit pattern to be stable,
// decodes it back to BCD, assembles a DIGITS-wide frame and hands it off on a
// valid/ready output register.
//   clk       in  1           rising-edge clock
//   rst_n     in  1           async active-low reset
//   seg       in  7           active-low segment lines (bit0=a .. bit6=g)
//   digit_sel in  DIGITS      active-low digit selects
//   ready     in  1           consumer ready
//   valid     out 1           frame presented
//   bcd       out 4*DIGITS    nibble k = digit k
//   blank     out DIGITS      digit k was dark
//   error     out DIGITS      digit k was an illegal pattern
//   overrun   out 1           pulse: a full, unsent frame had a slot overwritten
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     digit_sel,
  input  logic                  ready,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     error,
  output logic                  overrun
);

  localparam int              CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]   CNT_HIT = CW'(STABLE_CYCLES - 1);

  logic [6:0]              seg_q;
  logic [DIGITS-1:0]       sel_q;
  logic [CW-1:0]           cnt_q;
  logic                    same, one_low, accept;
  logic [DIGITS-1:0]       hit;

  logic [3:0]              dec_nib;
  logic                    dec_blank, dec_err;

  logic [DIGITS-1:0][3:0]  slot_nib;
  logic [DIGITS-1:0]       slot_blank, slot_err;
  logic [DIGITS-1:0]       mask_q, mask_d;
  state_e                  state_q, state_d;
  logic                    out_free, xfer, ovr_d;

  // Input sample and stability run length. The counter saturates so a long
  // stable run produces exactly one accept.
  assign same = (seg == seg_q) && (digit_sel == sel_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '1;
      sel_q <= '1;
      cnt_q <= '0;
    end else begin
      seg_q <= seg;
      sel_q <= digit_sel;
      if (!same)                cnt_q <= '0;
      else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Exactly one select low: hit is one-hot, which also serves as the slot enable.
  assign hit     = ~sel_q;
  assign one_low = (hit != '0) && ((hit & (hit - DIGITS'(1))) == '0);
  assign accept  = same && (cnt_q == CNT_HIT) && one_low;

  seg7_pattern_decode u_dec (
    .seg    (seg_q),
    .nibble (dec_nib),
    .blank  (dec_blank),
    .error  (dec_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_nib   <= '0;
      slot_blank <= '0;
      slot_err   <= '0;
    end else if (accept) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (hit[k]) begin
          slot_nib[k]   <= dec_nib;
          slot_blank[k] <= dec_blank;
          slot_err[k]   <= dec_err;
        end
      end
    end
  end

  // Frame FSM. The state simply tracks whether the capture mask is full.
  // An accept on the same edge as a transfer starts the next frame rather than
  // overwriting the departing one, so it does not count as an overrun.
  assign out_free = !valid || ready;

  always_comb begin
    mask_d = mask_q;
    xfer   = 1'b0;
    ovr_d  = 1'b0;
    case (state_q)
      COLLECT: if (accept) mask_d = mask_q | hit;
      FULL: begin
        if (out_free) begin
          xfer   = 1'b1;
          mask_d = accept ? hit : '0;
        end else if (accept) begin
          ovr_d = 1'b1;
        end
      end
      default: mask_d = '0;
    endcase
    state_d = (&mask_d) ? FULL : COLLECT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  // Output register: loads on transfer, otherwise drains on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      bcd     <= '0;
      blank   <= '0;
      error   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= ovr_d;
      if (xfer) begin
        valid <= 1'b1;
        bcd   <= slot_nib;
        blank <= slot_blank;
        error <= slot_err;
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (DIGITS=4, STABLE_CYCLES=4).
// Inputs are driven 1 time unit after the rising edge; handshakes and overrun
// pulses are collected on the falling edge.
module tb_seg7_scan_decoder;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SB = 7'b1111111, SX = 7'b0101010;

  logic        clk, rst_n, ready, valid, overrun;
  logic [6:0]  seg;
  logic [3:0]  digit_sel, blank, error;
  logic [15:0] bcd;

  int n_chk = 0;
  int n_err = 0;
  int ovr_cnt = 0;
  int exp_frames = 0;
  logic [23:0] frq[$];

  seg7_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg       (seg),
    .digit_sel (digit_sel),
    .ready     (ready),
    .valid     (valid),
    .bcd       (bcd),
    .blank     (blank),
    .error     (error),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid === 1'b1 && ready === 1'b1) frq.push_back({error, blank, bcd});
    if (overrun === 1'b1) ovr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hold one pattern for n cycles. With lat set, the pattern completes a frame
  // into an empty output register: accept lands on edge 5, valid after edge 6.
  task automatic show(input logic [6:0] s, input logic [3:0] sel, input int n,
                      input bit lat = 1'b0, input logic [15:0] eb = '0,
                      input logic [3:0] ebl = '0, input logic [3:0] eer = '0);
    seg = s;
    digit_sel = sel;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (lat && i == 5) chk("lat_early", valid, 1'b0);
      if (lat && i == 6) begin
        chk("lat_valid", valid, 1'b1);
        chk("lat_bcd",   bcd,   eb);
        chk("lat_blank", blank, ebl);
        chk("lat_error", error, eer);
      end
    end
  endtask

  task automatic scan4(input logic [6:0] d0, d1, d2, d3, input bit lat,
                       input logic [15:0] eb);
    show(d0, 4'b1110, 8);
    show(d1, 4'b1101, 8);
    show(d2, 4'b1011, 8);
    show(d3, 4'b0111, 8, lat, eb, 4'b0, 4'b0);
  endtask

  initial begin
    rst_n = 1'b0; ready = 1'b1; seg = '1; digit_sel = '1;
    repeat (3) @(posedge clk); #1;
    chk("rst_valid",   valid,   1'b0);
    chk("rst_bcd",     bcd,     16'h0);
    chk("rst_blank",   blank,   4'h0);
    chk("rst_error",   error,   4'h0);
    chk("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;

    // 1: plain scan
    scan4(S1, S2, S3, S4, 1'b1, 16'h4321);
    exp_frames++;
    repeat (2) @(posedge clk); #1;
    chk("t1_frames", frq.size(), exp_frames);
    chk("t1_frame", frq[0], {4'h0, 4'h0, 16'h4321});

    // 2: blank and illegal digits, reverse scan order
    show(S9, 4'b0111, 8);
    show(SB, 4'b1011, 8);
    show(S7, 4'b1101, 8);
    show(SX, 4'b1110, 8, 1'b1, 16'h9F7E, 4'b0100, 4'b0001);
    exp_frames++;
    repeat (2) @(posedge clk); #1;
    chk("t2_frames", frq.size(), exp_frames);

    // 3: short runs and multi-low selects never capture
    show(S5, 4'b1110, 3);
    show(S0, 4'b1110, 4);
    show(S8, 4'b1100, 10);
    show(S6, 4'b1101, 8);
    show(S7, 4'b1011, 8);
    show(S8, 4'b0111, 5);
    chk("t3_no_frame", frq.size(), exp_frames);
    chk("t3_no_valid", valid, 1'b0);
    show(S9, 4'b1110, 8, 1'b1, 16'h8769, 4'b0, 4'b0);
    exp_frames++;
    repeat (2) @(posedge clk); #1;
    chk("t3_frames", frq.size(), exp_frames);

    // 4: backpressure across three frames
    ready = 1'b0;
    scan4(S1, S2, S3, S4, 1'b1, 16'h4321);
    scan4(S5, S6, S7, S8, 1'b0, 16'h0);
    chk("t4_hold_valid", valid, 1'b1);
    chk("t4_hold_bcd", bcd, 16'h4321);
    chk("t4_no_ovr_yet", ovr_cnt, 0);
    scan4(S9, S0, S1, S2, 1'b0, 16'h0);
    chk("t4_hold_bcd2", bcd, 16'h4321);
    chk("t4_overruns", ovr_cnt, 4);
    ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_b2b_valid", valid, 1'b1);
    chk("t4_b2b_bcd", bcd, 16'h2109);
    @(posedge clk); #1;
    chk("t4_drain", valid, 1'b0);
    exp_frames += 2;
    chk("t4_frames", frq.size(), exp_frames);
    chk("t4_first", frq[exp_frames-2], {8'h0, 16'h4321});
    chk("t4_latest", frq[exp_frames-1], {8'h0, 16'h2109});

    // 5: continuous scan with ready tied high
    scan4(S3, S4, S5, S6, 1'b1, 16'h6543);
    scan4(S7, S8, S9, S0, 1'b1, 16'h0987);
    exp_frames += 2;
    repeat (2) @(posedge clk); #1;
    chk("t5_frames", frq.size(), exp_frames);
    chk("t5_last", frq[exp_frames-1], {8'h0, 16'h0987});

    // 6: async reset with a pending frame and a partial frame
    ready = 1'b0;
    scan4(S1, S1, S1, S1, 1'b1, 16'h1111);
    show(S2, 4'b1110, 8);
    show(S3, 4'b1101, 8);
    @(negedge clk); #2;
    chk("t6_pre_valid", valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", valid, 1'b0);
    chk("t6_rst_bcd", bcd, 16'h0);
    chk("t6_rst_ovr", overrun, 1'b0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    ready = 1'b1;
    show(S5, 4'b1011, 8);
    show(S6, 4'b0111, 8);
    chk("t6_partial_gone", frq.size(), exp_frames);
    chk("t6_no_valid", valid, 1'b0);
    show(S7, 4'b1110, 8);
    show(S8, 4'b1101, 8, 1'b1, 16'h6587, 4'b0, 4'b0);
    exp_frames++;
    repeat (3) @(posedge clk); #1;
    chk("t6_frames", frq.size(), exp_frames);
    chk("t6_overruns", ovr_cnt, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
